// File: rtl/md_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take 32 radix-2 steps plus one sign fix-up cycle; MTHI/MTLO are single-cycle.
module md_unit #(
    parameter int             W       = 32,
    parameter int             CNT_W   = 5,
    parameter logic [W-1:0]   DIV0_LO = 32'hFFFFFFFF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [2:0]   op_i,
    input  logic [W-1:0] rs_i,
    input  logic [W-1:0] rt_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [W-1:0]       hi_q;
    logic [W-1:0]       lo_q;
    logic [W-1:0]       acc_hi_q;
    logic [W-1:0]       acc_lo_q;
    logic [W-1:0]       opb_q;
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               div0_q;
    logic [W-1:0]       raw_a_q;

    logic               signed_op;
    logic [W-1:0]       a_abs;
    logic [W-1:0]       b_abs;
    logic [W:0]         mul_sum;
    logic [W:0]         div_shift;
    logic               div_ge;
    logic [W-1:0]       div_sub;
    logic [W-1:0]       step_hi_d;
    logic [W-1:0]       step_lo_d;
    logic [2*W-1:0]     prod_d;
    logic [W-1:0]       quo_d;
    logic [W-1:0]       rem_d;

    always_comb begin
        signed_op = ~op_i[0];
        a_abs     = (signed_op && rs_i[W-1]) ? -rs_i : rs_i;
        b_abs     = (signed_op && rt_i[W-1]) ? -rt_i : rt_i;

        // Multiply: LO holds the multiplier and shifts out one bit per step while
        // the partial product shifts in from HI.
        mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opb_q : {W{1'b0}})};

        // Restoring divide: LO holds the dividend and collects quotient bits.
        div_shift = {acc_hi_q, acc_lo_q[W-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_sub   = div_shift[W-1:0] - opb_q;

        step_hi_d = acc_hi_q;
        step_lo_d = acc_lo_q;
        if (is_div_q) begin
            step_hi_d = div_ge ? div_sub : div_shift[W-1:0];
            step_lo_d = {acc_lo_q[W-2:0], div_ge};
        end else begin
            step_hi_d = mul_sum[W:1];
            step_lo_d = {mul_sum[0], acc_lo_q[W-1:1]};
        end

        prod_d = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        quo_d  = neg_res_q ? -acc_lo_q : acc_lo_q;
        rem_d  = neg_rem_q ? -acc_hi_q : acc_hi_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            raw_a_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        case (op_i)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                acc_hi_q  <= '0;
                                acc_lo_q  <= a_abs;
                                opb_q     <= b_abs;
                                is_div_q  <= op_i[1];
                                neg_res_q <= signed_op & (rs_i[W-1] ^ rt_i[W-1]);
                                neg_rem_q <= signed_op & rs_i[W-1];
                                div0_q    <= (rt_i == '0);
                                raw_a_q   <= rs_i;
                                cnt_q     <= '0;
                                busy_q    <= 1'b1;
                                state_q   <= CALC;
                            end
                            3'd4:    hi_q <= rs_i;
                            3'd5:    lo_q <= rs_i;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc_hi_q <= step_hi_d;
                    acc_lo_q <= step_lo_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (!is_div_q) begin
                        hi_q <= prod_d[2*W-1:W];
                        lo_q <= prod_d[W-1:0];
                    end else if (div0_q) begin
                        hi_q <= raw_a_q;
                        lo_q <= DIV0_LO;
                    end else begin
                        hi_q <= rem_d;
                        lo_q <= quo_d;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table plus reference model, scoreboard of
// expected HI/LO popped on each done pulse, and hand sequences for reset/MT*/busy corners.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    md_unit dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .op_i    (op),
        .rs_i    (rs),
        .rt_i    (rt),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[12];
    int   errors = 0;
    int   checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        logic [63:0] res;
        res = '0;
        case (o)
            3'd0: res = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            3'd1: res = {32'h0, a} * {32'h0, b};
            3'd2: begin
                if (b == 32'h0) res = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = {32'h0, 32'h80000000};
                else begin
                    sa = $signed(a);
                    sb = $signed(b);
                    q  = sa / sb;
                    r  = sa % sb;
                    res = {32'(r), 32'(q)};
                end
            end
            3'd3: begin
                if (b == 32'h0) res = {a, 32'hFFFFFFFF};
                else res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest outstanding op.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_spurious: got done=1, expected done=0 (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check32("HI_result", hi, mon_e.hi);
                check32("LO_result", lo, mon_e.lo);
            end
        end
    end

    // Called at a negedge in IDLE; returns at a negedge one cycle after busy drops.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input bit inject);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          n;
        bit          moved;
        old_hi = hi;
        old_lo = lo;
        n      = 0;
        moved  = 1'b0;
        start  = 1'b1;
        op     = o;
        rs     = a;
        rt     = b;
        sb_q.push_back('{hi: eh, lo: el});
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        rs    = $urandom;
        rt    = $urandom;
        while (busy === 1'b1 && n < 100) begin
            if (hi !== old_hi || lo !== old_lo) moved = 1'b1;
            if (inject && n == 5) begin
                start = 1'b1;
                op    = 3'd5;
                rs    = 32'hDEADBEEF;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check32("busy_cycles", 32'(n), 32'd33);
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL hold_while_busy: got HI/LO changed during busy, expected %h/%h held", old_hi, old_lo);
        end
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL done_missing: got %0d results pending, expected 0", sb_q.size());
            sb_q.delete();
        end
        $display("op=%0d rs=%h rt=%h -> HI=%h LO=%h busy_cycles=%0d", o, a, b, hi, lo, n);
    endtask

    task automatic run_mt(input logic [2:0] o, input logic [31:0] a);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = hi;
        old_lo = lo;
        start  = 1'b1;
        op     = o;
        rs     = a;
        @(negedge clk);
        start = 1'b0;
        check32("mt_busy", {31'h0, busy}, 32'h0);
        check32("mt_HI", hi, (o == 3'd4) ? a : old_hi);
        check32("mt_LO", lo, (o == 3'd5) ? a : old_lo);
        @(negedge clk);
        $display("op=%0d rs=%h -> HI=%h LO=%h busy=%0b", o, a, hi, lo, busy);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] m;

        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[4]  = '{3'd2, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{3'd3, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[7]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{3'd0, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[9]  = '{3'd2, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2};
        vecs[10] = '{3'd2, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};
        vecs[11] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        // Reset with a pending MTHI request: reset must win.
        rst_n = 1'b0;
        start = 1'b1;
        op    = 3'd4;
        rs    = 32'h11111111;
        rt    = 32'h0;
        repeat (2) @(negedge clk);
        check32("rst_busy", {31'h0, busy}, 32'h0);
        check32("rst_done", {31'h0, done}, 32'h0);
        check32("rst_HI", hi, 32'h0);
        check32("rst_LO", lo, 32'h0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (i == 3) b = 32'h0;
            if (o >= 3'd2 && (i % 2) == 1) b = b >> 24;
            m = model(o, a, b);
            run_op(o, a, b, m[63:32], m[31:0], 1'b0);
        end

        run_mt(3'd4, 32'hA5A5A5A5);
        run_mt(3'd5, 32'h5A5A5A5A);
        run_mt(3'd6, 32'hCAFEF00D);
        run_mt(3'd7, 32'hBAADF00D);

        // MTLO issued mid-operation must be dropped.
        run_op(3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);

        // Reset in the middle of CALC aborts without touching HI/LO beyond clearing them.
        start = 1'b1;
        op    = 3'd1;
        rs    = 32'hFFFFFFFF;
        rt    = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check32("midcalc_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        start = 1'b1;
        op    = 3'd4;
        rs    = 32'h77777777;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        check32("abort_busy", {31'h0, busy}, 32'h0);
        check32("abort_done", {31'h0, done}, 32'h0);
        check32("abort_HI", hi, 32'h0);
        check32("abort_LO", lo, 32'h0);
        $display("reset mid-CALC -> HI=%h LO=%h busy=%0b", hi, lo, busy);
        repeat (40) @(negedge clk);
        check32("abort_idle", {31'h0, busy}, 32'h0);

        run_op(3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
